// File: rtl/mips_boot_dbg_ctrl.sv
// Boot/run/dump sequencer for the mips core: loads a program into instruction memory, releases
// the core until it halts or times out, then streams the first DUMP_REGS registers to the host.
module mips_boot_dbg_ctrl #(
    parameter int DW         = 32,
    parameter int PROG_DEPTH = 1024,
    parameter int DUMP_REGS  = 8,
    parameter int REG_AW     = 5,
    parameter int TIMEOUT    = 1000,
    parameter int CW         = 32,
    localparam int AW        = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [DW-1:0]     prog_data,
    input  logic              prog_last,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              cpu_clear,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic [REG_AW-1:0] reg_rd_addr,
    input  logic [DW-1:0]     reg_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DW-1:0]     dump_data,
    output logic [REG_AW-1:0] dump_idx,
    output logic [CW-1:0]     cycle_count,
    output logic              timed_out,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_DUMP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t            state_r;
    logic [AW-1:0]     load_ptr_r;
    logic [REG_AW-1:0] dump_idx_r;
    logic [CW-1:0]     cycle_count_r;
    logic              timed_out_r;
    logic              prog_ready_r;
    logic              cpu_clear_r;
    logic              cpu_run_r;
    logic              dump_valid_r;
    logic              done_r;

    logic              prog_hs_s;
    logic              dump_hs_s;
    logic              load_end_s;
    logic              start_ok_s;
    logic [CW-1:0]     count_inc_s;

    // Handshake qualifiers and the next-count value shared by the sequencer.
    always_comb begin
        prog_hs_s   = prog_valid & prog_ready_r;
        dump_hs_s   = dump_valid_r & dump_ready;
        load_end_s  = prog_last | (load_ptr_r == AW'(PROG_DEPTH - 1));
        start_ok_s  = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
        count_inc_s = cycle_count_r + CW'(1);
    end

    // Memory write port follows the load handshake in the same cycle; dump data is a pass-through
    // of the frozen regfile, zeroed whenever no dump beat is offered.
    always_comb begin
        prog_ready  = prog_ready_r;
        mem_we      = prog_hs_s;
        mem_addr    = prog_ready_r ? load_ptr_r : {AW{1'b0}};
        mem_wdata   = prog_hs_s ? prog_data : {DW{1'b0}};
        cpu_clear   = cpu_clear_r;
        cpu_run     = cpu_run_r;
        reg_rd_addr = dump_idx_r;
        dump_valid  = dump_valid_r;
        dump_data   = dump_valid_r ? reg_rd_data : {DW{1'b0}};
        dump_idx    = dump_idx_r;
        cycle_count = cycle_count_r;
        timed_out   = timed_out_r;
        done        = done_r;
    end

    // Sequencer state and all registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            load_ptr_r    <= {AW{1'b0}};
            dump_idx_r    <= {REG_AW{1'b0}};
            cycle_count_r <= {CW{1'b0}};
            timed_out_r   <= 1'b0;
            prog_ready_r  <= 1'b0;
            cpu_clear_r   <= 1'b0;
            cpu_run_r     <= 1'b0;
            dump_valid_r  <= 1'b0;
            done_r        <= 1'b0;
        end else if (start_ok_s) begin
            state_r       <= ST_LOAD;
            load_ptr_r    <= {AW{1'b0}};
            dump_idx_r    <= {REG_AW{1'b0}};
            cycle_count_r <= {CW{1'b0}};
            timed_out_r   <= 1'b0;
            prog_ready_r  <= 1'b1;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    prog_ready_r <= 1'b0;
                end
                ST_LOAD: begin
                    if (prog_hs_s) begin
                        load_ptr_r <= load_ptr_r + AW'(1);
                        // Last word or a full memory both end the load; later words are refused.
                        if (load_end_s) begin
                            state_r       <= ST_CLEAR;
                            prog_ready_r  <= 1'b0;
                            cpu_clear_r   <= 1'b1;
                            cycle_count_r <= {CW{1'b0}};
                        end
                    end
                end
                ST_CLEAR: begin
                    cpu_clear_r <= 1'b0;
                    cpu_run_r   <= 1'b1;
                    state_r     <= ST_RUN;
                end
                ST_RUN: begin
                    // A halt seen in the cycle that would hit TIMEOUT takes priority over the timeout.
                    if (cpu_halted) begin
                        cpu_run_r    <= 1'b0;
                        dump_valid_r <= 1'b1;
                        timed_out_r  <= 1'b0;
                        state_r      <= ST_DUMP;
                    end else begin
                        cycle_count_r <= count_inc_s;
                        if (count_inc_s == CW'(TIMEOUT)) begin
                            cpu_run_r    <= 1'b0;
                            dump_valid_r <= 1'b1;
                            timed_out_r  <= 1'b1;
                            state_r      <= ST_DUMP;
                        end
                    end
                end
                ST_DUMP: begin
                    if (dump_hs_s) begin
                        if (dump_idx_r == REG_AW'(DUMP_REGS - 1)) begin
                            dump_valid_r <= 1'b0;
                            done_r       <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            dump_idx_r <= dump_idx_r + REG_AW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b1;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    prog_ready_r <= 1'b0;
                    cpu_clear_r  <= 1'b0;
                    cpu_run_r    <= 1'b0;
                    dump_valid_r <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

endmodule
